conv_depth_accum: RTL and testbench
===================================

Name: conv_depth_accum

Overview:
- Streaming successor to the fixed-depth conv top-level result path.
- Accepts one multi-lane partial-sum vector per input channel. Accumulates D of them in place, with no D-wide result register.
- Adds a per-output-channel bias, applies a rounded arithmetic shift, saturates to int8, and presents the row over a valid/ready handshake.
- Sits between convLayerMulti and the next layer's line buffer. D is any positive integer, not only 1/2/4.

Parameters:
- D, 4, input channels (depth) per output group; must be >= 1.
- W, 6, output pixels per row.
- K, 8, output channels (filters).
- IN_W, 32, signed partial-sum width per lane.
- BIAS_W, 32, signed bias width per output channel.
- OUT_W, 8, signed output width per lane; saturation bound.
- SHIFT, 10, requantisation right-shift; 0 means no shift and no rounding.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rstn_i, input, 1: reset; synchronous, active-high despite the name.
- psum_i, input, IN_W*W*K: partial sums. Lane j = w*K+k sits at [j*IN_W +: IN_W].
- psum_valid_i, input, 1: psum_i valid.
- psum_ready_o, output, 1: block can accept psum_i.
- bias_i, input, BIAS_W*K: bias for channel k at [k*BIAS_W +: BIAS_W].
- depth_idx_o, output, DW=max(1,clog2(D)): index of the next beat to accept; drives kernel ROM address.
- out_data_o, output, OUT_W*W*K: requantised row, same lane packing as psum_i.
- out_valid_o, output, 1: out_data_o valid.
- out_ready_i, input, 1: consumer accepts out_data_o.
- busy_o, output, 1: high when a group is in progress (depth_idx_o != 0, or state FINAL or EMIT).

Behaviour:
- Internal accumulator per lane: AW = IN_W + clog2(D) + 1 bits, signed. Overflow is impossible by construction.
- State ACCUM:
  - psum_ready_o = 1.
  - On psum_valid_i & psum_ready_o with depth_idx_o == 0: acc = sext(psum_i), not acc + psum_i. No clear cycle is needed.
  - Any other accepted beat: acc += sext(psum_i); depth_idx_o increments.
  - On the beat where depth_idx_o == D-1: depth_idx_o wraps to 0 and the state goes to FINAL.
  - D == 1: every beat goes straight to FINAL.
- State FINAL (exactly 1 cycle):
  - psum_ready_o = 0.
  - Per lane: t = acc + sext(bias_i[k]). If SHIFT > 0, t += 1 << (SHIFT-1), then t >>>= SHIFT (arithmetic shift, i.e. round-half-up).
  - Saturate t to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register the result into out_data_o and set out_valid_o = 1. Go to EMIT.
  - bias_i is sampled in this cycle only.
- State EMIT:
  - psum_ready_o = 0; out_data_o and out_valid_o are held stable.
  - On out_valid_o & out_ready_i: out_valid_o = 0 next cycle and the state returns to ACCUM.
- Latency: out_valid_o rises 2 cycles after the last beat is accepted. Minimum period is D+2 cycles per group.
- Reset (any state, including mid-group): state = ACCUM, depth_idx_o = 0, out_valid_o = 0, out_data_o = 0, accumulators = 0. Any partial group is discarded.
- psum_valid_i while psum_ready_o = 0: ignored. The upstream must hold the beat.
- out_ready_i while out_valid_o = 0: no effect.
- X on psum_i while psum_valid_i = 0: must not propagate.

Optional Feature:
- Macro: CONV_DEPTH_ACCUM_RELU_EN.
- Defined: in FINAL, after the shift and before saturation, negative t is forced to 0. Outputs therefore lie in [0, 2^(OUT_W-1)-1].
- Undefined: signed saturation only; negative outputs pass.

Decomposition:
- Shared package conv_pkg holds:
  - localparams for AW and DW;
  - function sat_s(value, width);
  - function rshift_round(value, shift);
  - the state enum {ACCUM, FINAL, EMIT}.
- One sub-module, conv_lane_requant: combinational bias add, round, shift, optional ReLU and saturate for one lane. It is instantiated W*K times in a generate loop. The FSM, counter and accumulators stay in the top module.

Test Plan:
- Rounding (W=2, K=2, D=4, SHIFT=10, bias 0): all lanes 128 x4 -> every lane 1. All lanes 127 x4 -> every lane 0.
- Saturation: all lanes 0x00100000 x4 -> 127. All lanes -50000 x4 -> -128, or 0 with CONV_DEPTH_ACCUM_RELU_EN.
- Bias per channel: psum 0 x4 with bias_i = {k1: 2048, k0: -1024} -> lanes with k=1 give 2, lanes with k=0 give -1. Confirm the lane packing is correct.
- Backpressure: hold out_ready_i low for 5 cycles after out_valid_o -> out_data_o stable, psum_ready_o = 0, offered beats not consumed. Raise out_ready_i -> ACCUM the next cycle and depth_idx_o = 0.
- Reset mid-group: accept 2 beats of 5000, assert rstn_i for 1 cycle, then send 4 beats of 256 -> output 1, busy_o = 0 after the handshake.
- D=1 and D=3 builds with back-to-back psum_valid_i: out_valid_o 2 cycles after each last beat. depth_idx_o sequence is 0,1,2,0 for D=3 and constant 0 for D=1.

Source files
------------

// File: rtl/conv_depth_accum_pkg.sv
// Shared types and arithmetic helpers for the depth-accumulating conv result path.
// Helpers work on a wide signed type, so intermediate sums never overflow.
package conv_pkg;

    localparam int MAX_W = 128;
    typedef logic signed [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ACCUM,
        FINAL,
        EMIT
    } state_e;

    function automatic int calc_dw(input int d);
        return (d > 2) ? $clog2(d) : 1;
    endfunction

    function automatic int calc_aw(input int in_w, input int d);
        return in_w + $clog2(d) + 1;
    endfunction

    // Values for the default build (IN_W=32, D=4)
    localparam int DEF_DW = calc_dw(4);
    localparam int DEF_AW = calc_aw(32, 4);

    function automatic wide_t sat_s(input wide_t value, input int width);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        min_v = -max_v - wide_t'(1);
        if (value > max_v) return max_v;
        if (value < min_v) return min_v;
        return value;
    endfunction

    // Round half up, then arithmetic shift; shift of 0 is a pass-through
    function automatic wide_t rshift_round(input wide_t value, input int shift);
        if (shift <= 0) return value;
        return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/conv_lane_requant.sv
// One lane of requantisation: bias add, rounded shift, optional ReLU
// (CONV_DEPTH_ACCUM_RELU_EN), int saturation. Purely combinational, no backpressure.
module conv_lane_requant
    import conv_pkg::*;
#(
    parameter int AW     = 35,
    parameter int BIAS_W = 32,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 10
) (
    input  logic signed [AW-1:0]     acc_i,
    input  logic signed [BIAS_W-1:0] bias_i,
    output logic [OUT_W-1:0]         q_o
);

    wide_t sum_w;
    wide_t shr_w;

    always_comb begin
        sum_w = wide_t'(acc_i) + wide_t'(bias_i);
        shr_w = rshift_round(sum_w, SHIFT);
`ifdef CONV_DEPTH_ACCUM_RELU_EN
        if (shr_w < 0) shr_w = '0;
`endif
        q_o = OUT_W'(sat_s(shr_w, OUT_W));
    end

endmodule

// File: rtl/conv_depth_accum.sv
// Accumulates D psum beats per lane in place, then requantises the row (ReLU via CONV_DEPTH_ACCUM_RELU_EN).
// out_valid_o rises 2 cycles after the last beat; psum_ready_o drops in FINAL/EMIT until the row is taken.
module conv_depth_accum
    import conv_pkg::*;
#(
    parameter int D      = 4,
    parameter int W      = 6,
    parameter int K      = 8,
    parameter int IN_W   = 32,
    parameter int BIAS_W = 32,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 10
) (
    input  logic                         clk,
    input  logic                         rstn_i,
    input  logic [IN_W*W*K-1:0]          psum_i,
    input  logic                         psum_valid_i,
    output logic                         psum_ready_o,
    input  logic [BIAS_W*K-1:0]          bias_i,
    output logic [calc_dw(D)-1:0]        depth_idx_o,
    output logic [OUT_W*W*K-1:0]         out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o
);

    localparam int L  = W * K;
    localparam int AW = calc_aw(IN_W, D);
    localparam int DW = calc_dw(D);

    state_e                state_q, state_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic signed [AW-1:0]  acc_q [L];
    logic signed [AW-1:0]  acc_d [L];
    logic [OUT_W*L-1:0]    out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W*L-1:0]    requant_dat;
    logic                  psum_fire;

    assign psum_fire = psum_valid_i && (state_q == ACCUM);

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int j = 0; j < L; j++) acc_d[j] = acc_q[j];

        case (state_q)
            ACCUM: begin
                if (psum_fire) begin
                    // First beat of a group loads instead of adding, so no clear cycle is needed
                    for (int j = 0; j < L; j++) begin
                        acc_d[j] = ((depth_q == '0) ? '0 : acc_q[j])
                                 + AW'(signed'(psum_i[j*IN_W +: IN_W]));
                    end
                    if (depth_q == DW'(D - 1)) begin
                        depth_d = '0;
                        state_d = FINAL;
                    end else begin
                        depth_d = depth_q + DW'(1);
                    end
                end
            end
            FINAL: begin
                out_data_d  = requant_dat;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn_i) begin
            state_q     <= ACCUM;
            depth_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < L; j++) acc_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int j = 0; j < L; j++) acc_q[j] <= acc_d[j];
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lane
        conv_lane_requant #(
            .AW     (AW),
            .BIAS_W (BIAS_W),
            .OUT_W  (OUT_W),
            .SHIFT  (SHIFT)
        ) u_requant (
            .acc_i  (acc_q[j]),
            .bias_i (bias_i[(j % K)*BIAS_W +: BIAS_W]),
            .q_o    (requant_dat[j*OUT_W +: OUT_W])
        );
    end

    assign psum_ready_o = (state_q == ACCUM);
    assign depth_idx_o  = depth_q;
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = (depth_q != '0) || (state_q != ACCUM);

endmodule

// File: tb/tb_conv_depth_accum.sv
// Directed bench for conv_depth_accum: D=4 main instance plus D=3 and D=1 streaming instances.
module tb_conv_depth_accum;

    localparam int W = 2, K = 2, IN_W = 32, BIAS_W = 32, OUT_W = 8, SHIFT = 10;
    localparam int L = W * K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Main D=4 instance
    logic                  rst;
    logic [IN_W*L-1:0]     psum;
    logic                  psum_vld;
    logic                  psum_rdy;
    logic [BIAS_W*K-1:0]   bias;
    logic [1:0]            depth;
    logic [OUT_W*L-1:0]    out_dat;
    logic                  out_vld;
    logic                  out_rdy;
    logic                  busy;

    conv_depth_accum #(.D(4), .W(W), .K(K), .IN_W(IN_W), .BIAS_W(BIAS_W),
                       .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rstn_i(rst), .psum_i(psum), .psum_valid_i(psum_vld),
        .psum_ready_o(psum_rdy), .bias_i(bias), .depth_idx_o(depth),
        .out_data_o(out_dat), .out_valid_o(out_vld), .out_ready_i(out_rdy), .busy_o(busy)
    );

    // Streaming D=3 / D=1 instances, selected by sel
    logic                  sel;
    logic                  vld_s;
    logic [IN_W*L-1:0]     psum_s;
    logic                  rdy3, rdy1, ov3, ov1, busy3, busy1;
    logic [1:0]            depth3;
    logic [0:0]            depth1;
    logic [OUT_W*L-1:0]    od3, od1;
    logic [BIAS_W*K-1:0]   bias_zero = '0;
    logic                  ordy_one = 1'b1;
    logic                  vld3, vld1;

    assign vld3 = vld_s && !sel;
    assign vld1 = vld_s && sel;

    conv_depth_accum #(.D(3), .W(W), .K(K), .IN_W(IN_W), .BIAS_W(BIAS_W),
                       .OUT_W(OUT_W), .SHIFT(SHIFT)) dut3 (
        .clk(clk), .rstn_i(rst), .psum_i(psum_s), .psum_valid_i(vld3),
        .psum_ready_o(rdy3), .bias_i(bias_zero), .depth_idx_o(depth3),
        .out_data_o(od3), .out_valid_o(ov3), .out_ready_i(ordy_one), .busy_o(busy3)
    );

    conv_depth_accum #(.D(1), .W(W), .K(K), .IN_W(IN_W), .BIAS_W(BIAS_W),
                       .OUT_W(OUT_W), .SHIFT(SHIFT)) dut1 (
        .clk(clk), .rstn_i(rst), .psum_i(psum_s), .psum_valid_i(vld1),
        .psum_ready_o(rdy1), .bias_i(bias_zero), .depth_idx_o(depth1),
        .out_data_o(od1), .out_valid_o(ov1), .out_ready_i(ordy_one), .busy_o(busy1)
    );

    logic              s_rdy, s_vld, s_busy;
    logic [1:0]        s_depth;
    logic [OUT_W*L-1:0] s_dat;
    assign s_rdy   = sel ? rdy1  : rdy3;
    assign s_vld   = sel ? ov1   : ov3;
    assign s_busy  = sel ? busy1 : busy3;
    assign s_dat   = sel ? od1   : od3;
    assign s_depth = sel ? {1'b0, depth1} : depth3;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [OUT_W*L-1:0] expbus(input int e0, input int e1);
        logic [OUT_W*L-1:0] r;
        r = '0;
        for (int w = 0; w < W; w++)
            for (int k = 0; k < K; k++)
                r[(w*K+k)*OUT_W +: OUT_W] = (k == 1) ? e1[OUT_W-1:0] : e0[OUT_W-1:0];
        return r;
    endfunction

    // Drives n beats of value v on every lane; returns at the negedge after the last acceptance
    task automatic send_beats(input int v, input int n);
        logic [IN_W-1:0] vv;
        vv = v;
        for (int i = 0; i < n; i++) begin
            int g;
            @(negedge clk);
            g = 0;
            while (!psum_rdy && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("beat_ready", psum_rdy, 1);
            psum     = {L{vv}};
            psum_vld = 1'b1;
        end
        @(negedge clk);
        psum_vld = 1'b0;
        psum     = 'x;
    endtask

    // Called in the FINAL cycle; checks latency, the row, and optionally handshakes it
    task automatic finish_group(input string nm, input int e0, input int e1, input bit hs);
        chk({nm, "_final_vld"}, out_vld, 0);
        chk({nm, "_final_busy"}, busy, 1);
        @(negedge clk);
        chk({nm, "_emit_vld"}, out_vld, 1);
        chk({nm, "_lanes"}, out_dat, expbus(e0, e1));
        chk({nm, "_emit_rdy"}, psum_rdy, 0);
        if (hs) begin
            out_rdy = 1'b1;
            @(negedge clk);
            out_rdy = 1'b0;
            chk({nm, "_hs_vld"}, out_vld, 0);
            chk({nm, "_hs_busy"}, busy, 0);
            chk({nm, "_hs_rdy"}, psum_rdy, 1);
        end
    endtask

    // Back-to-back valid into the selected streaming instance, checked cycle by cycle
    task automatic run_stream(input logic s, input int d, input int val, input int ex, input int ncyc);
        int cnt, last;
        logic [IN_W-1:0]  vv;
        logic [OUT_W-1:0] e8;
        logic exp_rdy;
        cnt  = 0;
        last = -100;
        vv   = val;
        e8   = ex[OUT_W-1:0];
        sel    = s;
        psum_s = {L{vv}};
        @(negedge clk);
        vld_s = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            exp_rdy = !((c == last + 1) || (c == last + 2));
            chk("stream_rdy", s_rdy, exp_rdy);
            chk("stream_vld", s_vld, (c == last + 2));
            if (s_vld) chk("stream_dat", s_dat, {L{e8}});
            if (exp_rdy && s_rdy) begin
                chk("stream_depth", s_depth, cnt % d);
                if (cnt % d == d - 1) last = c;
                cnt++;
            end
            @(negedge clk);
        end
        vld_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream_busy", s_busy, (cnt % d) != 0);
    endtask

    typedef struct {
        int v;
        int b0;
        int b1;
        int e0;
        int e1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BIAS_W-1:0] b0, b1;

        tbl[0] = '{128, 0, 0, 1, 1};
        tbl[1] = '{127, 0, 0, 0, 0};
        tbl[2] = '{32'h0010_0000, 0, 0, 127, 127};
`ifdef CONV_DEPTH_ACCUM_RELU_EN
        tbl[3] = '{-50000, 0, 0, 0, 0};
        tbl[4] = '{0, -1024, 2048, 0, 2};
        tbl[5] = '{300, 0, -2000, 1, 0};
`else
        tbl[3] = '{-50000, 0, 0, -128, -128};
        tbl[4] = '{0, -1024, 2048, -1, 2};
        tbl[5] = '{300, 0, -2000, 1, -1};
`endif

        rst      = 1'b1;
        psum     = '0;
        psum_vld = 1'b0;
        out_rdy  = 1'b0;
        bias     = '0;
        sel      = 1'b0;
        vld_s    = 1'b0;
        psum_s   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_rdy", psum_rdy, 1);
        chk("reset_vld", out_vld, 0);
        chk("reset_depth", depth, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dat", out_dat, 0);

        for (int i = 0; i < 6; i++) begin
            b0 = tbl[i].b0;
            b1 = tbl[i].b1;
            bias = {b1, b0};
            send_beats(tbl[i].v, 4);
            finish_group($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, 1'b1);
        end
        bias = '0;

        // Backpressure: row held, extra beats refused
        send_beats(128, 4);
        finish_group("bp", 1, 1, 1'b0);
        psum     = {L{32'd999}};
        psum_vld = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld", out_vld, 1);
            chk("bp_dat", out_dat, expbus(1, 1));
            chk("bp_rdy", psum_rdy, 0);
            chk("bp_depth", depth, 0);
        end
        psum_vld = 1'b0;
        out_rdy  = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        chk("bp_release_rdy", psum_rdy, 1);
        chk("bp_release_depth", depth, 0);
        chk("bp_release_vld", out_vld, 0);
        send_beats(128, 4);
        finish_group("bp_after", 1, 1, 1'b1);

        // Reset in the middle of a group
        send_beats(5000, 2);
        chk("mid_depth", depth, 2);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_dat", out_dat, 0);
        send_beats(256, 4);
        finish_group("mid_after", 1, 1, 1'b1);

        run_stream(1'b0, 3, 512, 2, 15);
        run_stream(1'b1, 1, 1024, 1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
